// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer sizing, parameter checks
// and the type used for occupancy thresholds.
package fifo_pkg;

    // Pointer carries one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    typedef int unsigned occ_lvl_t;

endpackage

// File: rtl/ram_partial_dp_scd.sv
// Single-clock RAM with one write port and one combinational read port.
// Read data is zero while re is low; a same-address write is forwarded.
module ram_partial_dp_scd
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]    w_data,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] r_addr,
    output logic [DATA_WIDTH-1:0]    r_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    always_comb begin
        r_data = '0;
        if (re) begin
            if (we && (w_addr == r_addr)) begin
                r_data = w_data;
            end else begin
                r_data = mem[r_addr];
            end
        end
    end

endmodule

// File: rtl/fifo_sync_scd.sv
// Single-clock FWFT FIFO controller: valid/ready ingress, valid/ready egress,
// wrap-bit pointers plus a registered occupancy count and threshold flags.
module fifo_sync_scd
    import fifo_pkg::*;
#(
    parameter int       DEPTH      = 16,
    parameter int       DATA_WIDTH = 8,
    parameter occ_lvl_t AFULL_LVL  = DEPTH - 2,
    parameter occ_lvl_t AEMPTY_LVL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty
);

    localparam int AdrBits = $clog2(DEPTH);
    localparam int PtrW    = ptr_width(DEPTH);
    localparam logic [PtrW-1:0] AfullC  = PtrW'(AFULL_LVL);
    localparam logic [PtrW-1:0] AemptyC = PtrW'(AEMPTY_LVL);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_scd: DEPTH must be a power of two and at least 2");
    end

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] count_q;
    logic [PtrW-1:0] ptr_diff;
    logic            push;
    logic            pop;
    logic            ram_we;
    logic            ram_re;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AdrBits-1:0] == rd_ptr[AdrBits-1:0]) &&
                      (wr_ptr[AdrBits] != rd_ptr[AdrBits]);
    assign ptr_diff = wr_ptr - rd_ptr;

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign count        = count_q;
    assign almost_full  = (count_q >= AfullC);
    assign almost_empty = (count_q <= AemptyC);

    assign ram_we = push;
    assign ram_re = !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The registered count is a convenience copy; it must track the pointers.
    a_count_matches_ptrs : assert property (
        @(posedge clk) disable iff (!rst_n) count_q == ptr_diff
    );

    ram_partial_dp_scd #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .w_addr (wr_ptr[AdrBits-1:0]),
        .w_data (in_data),
        .re     (ram_re),
        .r_addr (rd_ptr[AdrBits-1:0]),
        .r_data (out_data)
    );

endmodule

// File: tb/tb_fifo_sync_scd.sv
// Directed bench for fifo_sync_scd (DEPTH=16, 8-bit): vector table plus
// hand sequences for fill/drain, wrap, full-boundary, flush and reset.
module tb_fifo_sync_scd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;

    int n_cmp  = 0;
    int n_fail = 0;
    int collisions = 0;

    always #5 clk = ~clk;

    fifo_sync_scd #(
        .DEPTH      (16),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Write and read of the same RAM word in one cycle must never happen.
    always @(posedge clk) begin
        if (dut.ram_we && dut.ram_re && (dut.wr_ptr[3:0] == dut.rd_ptr[3:0]))
            collisions++;
    end

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic       e_af;
        logic       e_ae;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        //            rst fl iv data   or  cnt emp ful ov  od     ir af ae
        vecs[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
        vecs[1]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
        vecs[2]  = '{1'b1,1'b0,1'b1,8'hA5,1'b0, 5'd1,1'b0,1'b0,1'b1,8'hA5,1'b1,1'b0,1'b1};
        vecs[3]  = '{1'b1,1'b0,1'b1,8'h3C,1'b1, 5'd1,1'b0,1'b0,1'b1,8'h3C,1'b1,1'b0,1'b1};
        vecs[4]  = '{1'b1,1'b0,1'b1,8'h11,1'b0, 5'd2,1'b0,1'b0,1'b1,8'h3C,1'b1,1'b0,1'b1};
        vecs[5]  = '{1'b1,1'b0,1'b1,8'h22,1'b0, 5'd3,1'b0,1'b0,1'b1,8'h3C,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 5'd2,1'b0,1'b0,1'b1,8'h11,1'b1,1'b0,1'b1};
        vecs[7]  = '{1'b1,1'b1,1'b1,8'h77,1'b1, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
        vecs[8]  = '{1'b1,1'b0,1'b1,8'h5A,1'b0, 5'd1,1'b0,1'b0,1'b1,8'h5A,1'b1,1'b0,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
        vecs[10] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
        vecs[11] = '{1'b1,1'b0,1'b1,8'h66,1'b0, 5'd1,1'b0,1'b0,1'b1,8'h66,1'b1,1'b0,1'b1};
        vecs[12] = '{1'b0,1'b0,1'b1,8'h99,1'b1, 5'd0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};

        tick();
        for (int i = 0; i < 13; i++) begin
            rst_n = vecs[i].rst_n;
            flush = vecs[i].flush;
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            tick();
            chk($sformatf("vec%0d", i),
                int'({count, empty, full, out_valid, out_data, in_ready, almost_full, almost_empty}),
                int'({vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ov,
                      vecs[i].e_od, vecs[i].e_ir, vecs[i].e_af, vecs[i].e_ae}));
        end
        rst_n = 1'b1; flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick();

        // Fill to full, confirm hold-off, drain in order.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
            chk($sformatf("fill_cnt%0d", i), int'(count), i);
            chk($sformatf("fill_af%0d", i), int'(almost_full), (i >= 14) ? 1 : 0);
        end
        chk("full_flag", int'(full), 1);
        chk("full_in_ready", int'(in_ready), 0);
        drive(1'b1, 8'hFF, 1'b0);
        tick();
        chk("full_holdoff_cnt", int'(count), 16);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk($sformatf("drain%0d", i), int'(out_data), i);
            tick();
        end
        chk("drain_empty", int'(empty), 1);
        drive(1'b0, 8'h00, 1'b0);

        // Push into empty is not visible until after the edge.
        drive(1'b1, 8'hA5, 1'b0);
        #1;
        chk("nobypass_ov", int'(out_valid), 0);
        chk("nobypass_od", int'(out_data), 0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("fwft_ov", int'(out_valid), 1);
        chk("fwft_od", int'(out_data), 8'hA5);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk("fwft_pop_empty", int'(empty), 1);

        // Streaming at occupancy 8 across two pointer wraps.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(8 + i), 1'b1);
            chk($sformatf("stream_od%0d", i), int'(out_data), i);
            tick();
            chk($sformatf("stream_cnt%0d", i), int'(count), 8);
        end
        for (int i = 40; i < 48; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk($sformatf("stream_tail%0d", i), int'(out_data), i);
            tick();
        end
        chk("stream_empty", int'(empty), 1);

        // Full with pop and push together: pop only, push lands next cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b1);
        chk("fullpp_in_ready", int'(in_ready), 0);
        tick();
        chk("fullpp_cnt", int'(count), 15);
        chk("fullpp_head", int'(out_data), 8'h21);
        chk("fullpp_ready_back", int'(in_ready), 1);
        drive(1'b1, 8'hEE, 1'b0);
        tick();
        chk("fullpp_refill_cnt", int'(count), 16);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk($sformatf("fullpp_drain%0d", i), int'(out_data), 8'h20 + i);
            tick();
        end
        chk("fullpp_last", int'(out_data), 8'hEE);
        tick();
        chk("fullpp_empty", int'(empty), 1);

        // Flush beats a simultaneous push.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("flush_cnt", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        tick();
        chk("flush_idle_ov", int'(out_valid), 0);
        drive(1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        chk("flush_next_head", int'(out_data), 8'h01);
        tick();

        // Reset mid-burst discards entries and the in-flight push.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b1, 8'h77, 1'b1);
        tick();
        chk("rst_cnt", int'(count), 0);
        chk("rst_flags", int'({empty, full, out_valid, in_ready, almost_empty}), 5'b10011);
        chk("rst_od", int'(out_data), 0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        chk("rst_idle_ov", int'(out_valid), 0);

        chk("ram_collisions", collisions, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
